// File: rtl/mem_arbiter_ctrl_pkg.sv
// Shared types for the memory arbiter: FSM state encoding and grant-side encoding.
package mem_arbiter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DWRITE = 2'd1,
    DFILL  = 2'd2,
    IFILL  = 2'd3
  } arb_state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_ctrl_if.sv
// Bus bundle between the arbiter, the two cache miss paths and main memory.
// master = arbiter side, slave = caches + memory side.
interface mem_arbiter_ctrl_if #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = 8
);
  localparam int IDX_W = $clog2(BLOCK_WORDS);

  logic              i_fill_req;
  logic [ADDR_W-1:0] i_fill_addr;
  logic              d_fill_req;
  logic [ADDR_W-1:0] d_fill_addr;
  logic              d_wr_req;
  logic [ADDR_W-1:0] d_wr_addr;
  logic [DATA_W-1:0] d_wr_data;
  logic              mem_rd_valid;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              fill_word_vld;
  logic [IDX_W-1:0]  fill_word_idx;
  logic [DATA_W-1:0] fill_data;
  logic              i_fill_done;
  logic              d_fill_done;
  logic              d_wr_done;
  logic              i_busy;
  logic              d_busy;

  modport master (
    input  i_fill_req, i_fill_addr, d_fill_req, d_fill_addr,
    input  d_wr_req, d_wr_addr, d_wr_data, mem_rd_valid, mem_rd_data,
    output mem_en, mem_wr, mem_addr, mem_wr_data,
    output fill_word_vld, fill_word_idx, fill_data,
    output i_fill_done, d_fill_done, d_wr_done, i_busy, d_busy
  );

  modport slave (
    output i_fill_req, i_fill_addr, d_fill_req, d_fill_addr,
    output d_wr_req, d_wr_addr, d_wr_data, mem_rd_valid, mem_rd_data,
    input  mem_en, mem_wr, mem_addr, mem_wr_data,
    input  fill_word_vld, fill_word_idx, fill_data,
    input  i_fill_done, d_fill_done, d_wr_done, i_busy, d_busy
  );

endinterface

// File: rtl/mem_arbiter_ctrl_burst_cnt.sv
// Issue and return word counters for one block burst.
// issue_cnt holds at the last word once all reads are issued; ret_cnt wraps.
module mem_burst_cnt #(
  parameter int BLOCK_WORDS = 8,
  parameter int IDX_W       = $clog2(BLOCK_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             issue_en,
  input  logic             ret_en,
  output logic [IDX_W-1:0] issue_cnt,
  output logic [IDX_W-1:0] ret_cnt,
  output logic             issue_done,
  output logic             ret_done
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(BLOCK_WORDS - 1);

  logic [IDX_W-1:0] issue_cnt_q, issue_cnt_d, ret_cnt_q, ret_cnt_d;
  logic             issue_done_q, issue_done_d, ret_done_q, ret_done_d;

  // Advance counters; done flags freeze further counting until cleared
  always_comb begin
    issue_cnt_d  = issue_cnt_q;
    ret_cnt_d    = ret_cnt_q;
    issue_done_d = issue_done_q;
    ret_done_d   = ret_done_q;
    if (clr) begin
      issue_cnt_d  = '0;
      ret_cnt_d    = '0;
      issue_done_d = 1'b0;
      ret_done_d   = 1'b0;
    end else begin
      if (issue_en && !issue_done_q) begin
        if (issue_cnt_q == LAST) issue_done_d = 1'b1;
        else                     issue_cnt_d  = issue_cnt_q + IDX_W'(1);
      end
      if (ret_en && !ret_done_q) begin
        ret_cnt_d = ret_cnt_q + IDX_W'(1);
        if (ret_cnt_q == LAST) ret_done_d = 1'b1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt_q  <= '0;
      ret_cnt_q    <= '0;
      issue_done_q <= 1'b0;
      ret_done_q   <= 1'b0;
    end else begin
      issue_cnt_q  <= issue_cnt_d;
      ret_cnt_q    <= ret_cnt_d;
      issue_done_q <= issue_done_d;
      ret_done_q   <= ret_done_d;
    end
  end

  assign issue_cnt  = issue_cnt_q;
  assign ret_cnt    = ret_cnt_q;
  assign issue_done = issue_done_q;
  assign ret_done   = ret_done_q;

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Shared main-memory arbiter: D-store > D-fill > I-fill.
// Define ARB_ROUND_ROBIN_EN to alternate between D-fill and I-fill (store stays on top).
module mem_arbiter_ctrl
  import mem_arbiter_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int MEM_LAT     = 4,
  parameter int BLOCK_WORDS = 8
) (
  input logic               clk,
  input logic               rst,
  mem_arbiter_ctrl_if.master bus
);

  localparam int IDX_W    = $clog2(BLOCK_WORDS);
  localparam int WR_CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [WR_CNT_W-1:0] WR_CNT_INIT = WR_CNT_W'(MEM_LAT - 1);

  arb_state_t        state_q, state_d;
  logic              i_req_q, i_req_d, d_fill_req_q, d_fill_req_d, d_wr_req_q, d_wr_req_d;
  logic [ADDR_W-1:0] i_addr_q, i_addr_d, d_fill_addr_q, d_fill_addr_d, d_wr_addr_q, d_wr_addr_d;
  logic [DATA_W-1:0] d_wr_data_q, d_wr_data_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, fill_data_q, fill_data_d;
  logic [WR_CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic              fill_vld_q, fill_vld_d;
  logic [IDX_W-1:0]  fill_idx_q, fill_idx_d;
  logic              i_done_q, i_done_d, d_done_q, d_done_d, wr_done_q, wr_done_d;
  logic              cnt_clr, issue_en, ret_en, issue_done, ret_done, fill_state;
  logic [IDX_W-1:0]  issue_cnt, ret_cnt;
  logic              mem_en, mem_wr;
  logic              i_eff, d_fill_eff, d_wr_eff, pick_d;

  mem_burst_cnt #(.BLOCK_WORDS(BLOCK_WORDS), .IDX_W(IDX_W)) u_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .issue_en(issue_en), .ret_en(ret_en),
    .issue_cnt(issue_cnt), .ret_cnt(ret_cnt), .issue_done(issue_done), .ret_done(ret_done)
  );

  // Request sample; arbitration only looks at this registered copy
  always_comb begin
    i_req_d       = bus.i_fill_req;
    i_addr_d      = bus.i_fill_addr;
    d_fill_req_d  = bus.d_fill_req;
    d_fill_addr_d = bus.d_fill_addr;
    d_wr_req_d    = bus.d_wr_req;
    d_wr_addr_d   = bus.d_wr_addr;
    d_wr_data_d   = bus.d_wr_data;
  end

  // A request whose done is pulsing now is still high in the sample; ignore it
  assign i_eff      = i_req_q      && !i_done_q;
  assign d_fill_eff = d_fill_req_q && !d_done_q;
  assign d_wr_eff   = d_wr_req_q   && !wr_done_q;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;

  assign pick_d = d_fill_eff && (!i_eff || (last_grant_q == GRANT_I));

  // Remember which fill side was granted last
  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == IDLE && !d_wr_eff) begin
      if (pick_d)     last_grant_d = GRANT_D;
      else if (i_eff) last_grant_d = GRANT_I;
    end
  end

  // Last-grant register, starts on I so D is served first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= GRANT_I;
    else     last_grant_q <= last_grant_d;
  end
`else
  assign pick_d = d_fill_eff;
`endif

  // Next state, grant and memory issue
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    wdata_d    = wdata_q;
    wr_cnt_d   = wr_cnt_q;
    i_done_d   = 1'b0;
    d_done_d   = 1'b0;
    wr_done_d  = 1'b0;
    cnt_clr    = 1'b0;
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (d_wr_eff) begin
          state_d    = DWRITE;
          cur_addr_d = d_wr_addr_q;
          wdata_d    = d_wr_data_q;
          wr_cnt_d   = WR_CNT_INIT;
        end else if (pick_d) begin
          state_d    = DFILL;
          cur_addr_d = d_fill_addr_q;
        end else if (i_eff) begin
          state_d    = IFILL;
          cur_addr_d = i_addr_q;
        end
      end
      DWRITE: begin
        mem_en = (wr_cnt_q == WR_CNT_INIT);
        mem_wr = mem_en;
        if (wr_cnt_q == '0) begin
          state_d   = IDLE;
          wr_done_d = 1'b1;
        end else begin
          wr_cnt_d = wr_cnt_q - WR_CNT_W'(1);
        end
      end
      DFILL, IFILL: begin
        mem_en = !issue_done;
        if (ret_done) begin
          state_d  = IDLE;
          d_done_d = (state_q == DFILL);
          i_done_d = (state_q == IFILL);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fill_state = (state_q == DFILL) || (state_q == IFILL);
  assign issue_en   = mem_en && !mem_wr;
  assign ret_en     = fill_state && bus.mem_rd_valid && !ret_done;

  // Capture returning read data for the granted cache
  always_comb begin
    fill_vld_d  = ret_en;
    fill_idx_d  = ret_en ? ret_cnt : fill_idx_q;
    fill_data_d = ret_en ? bus.mem_rd_data : fill_data_q;
  end

  // State, sample and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      i_req_q       <= 1'b0;
      i_addr_q      <= '0;
      d_fill_req_q  <= 1'b0;
      d_fill_addr_q <= '0;
      d_wr_req_q    <= 1'b0;
      d_wr_addr_q   <= '0;
      d_wr_data_q   <= '0;
      cur_addr_q    <= '0;
      wdata_q       <= '0;
      wr_cnt_q      <= '0;
      fill_vld_q    <= 1'b0;
      fill_idx_q    <= '0;
      fill_data_q   <= '0;
      i_done_q      <= 1'b0;
      d_done_q      <= 1'b0;
      wr_done_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      i_req_q       <= i_req_d;
      i_addr_q      <= i_addr_d;
      d_fill_req_q  <= d_fill_req_d;
      d_fill_addr_q <= d_fill_addr_d;
      d_wr_req_q    <= d_wr_req_d;
      d_wr_addr_q   <= d_wr_addr_d;
      d_wr_data_q   <= d_wr_data_d;
      cur_addr_q    <= cur_addr_d;
      wdata_q       <= wdata_d;
      wr_cnt_q      <= wr_cnt_d;
      fill_vld_q    <= fill_vld_d;
      fill_idx_q    <= fill_idx_d;
      fill_data_q   <= fill_data_d;
      i_done_q      <= i_done_d;
      d_done_q      <= d_done_d;
      wr_done_q     <= wr_done_d;
    end
  end

  assign bus.mem_en        = mem_en;
  assign bus.mem_wr        = mem_wr;
  assign bus.mem_addr      = !mem_en ? '0 :
                             mem_wr  ? cur_addr_q :
                                       {cur_addr_q[ADDR_W-1:IDX_W+1], issue_cnt, 1'b0};
  assign bus.mem_wr_data   = (mem_en && mem_wr) ? wdata_q : '0;
  assign bus.fill_word_vld = fill_vld_q;
  assign bus.fill_word_idx = fill_idx_q;
  assign bus.fill_data     = fill_data_q;
  assign bus.i_fill_done   = i_done_q;
  assign bus.d_fill_done   = d_done_q;
  assign bus.d_wr_done     = wr_done_q;
  assign bus.i_busy        = bus.i_fill_req && !i_done_q;
  assign bus.d_busy        = (bus.d_fill_req && !d_done_q) || (bus.d_wr_req && !wr_done_q);

endmodule
